// File: rtl/mem_port_arbiter.sv
// Single-port main-memory arbiter: grants one instruction FSM at a time, runs the EN/RW/MFC handshake with timeout.
// Build option ARB_FIXED_PRIO_EN selects fixed priority (index 0 highest) instead of round-robin.
module mem_port_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 15,
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW     = $clog2(TIMEOUT + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] rw_req,
  input  logic            MFC,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            EN,
  output logic            RW,
  output logic [NREQ-1:0] done,
  output logic            err,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_ACCESS  = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            dir;
  logic            ok;
  logic [IDW-1:0]  pick;
  logic [NREQ-1:0] onehot;

  function automatic logic [IDW-1:0] lowest(input logic [NREQ-1:0] v);
    lowest = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (v[i]) lowest = IDW'(i);
    end
  endfunction

`ifdef ARB_FIXED_PRIO_EN
  always_comb begin
    pick = lowest(req);
  end
`else
  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] req_masked;

  // Requests at or above the pointer win first; otherwise wrap to the lowest set bit.
  always_comb begin
    req_masked = req & ~((NREQ'(1) << ptr) - NREQ'(1));
    pick       = (|req_masked) ? lowest(req_masked) : lowest(req);
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (|req) state_nxt = S_GRANT;
      S_GRANT:   state_nxt = S_ACCESS;
      S_ACCESS:  if (MFC || (cnt == CW'(TIMEOUT - 1))) state_nxt = S_RELEASE;
      S_RELEASE: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_id <= '0;
      dir    <= 1'b0;
      cnt    <= '0;
      ok     <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
      ptr    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            gnt_id <= pick;
            dir    <= rw_req[pick];
          end
        end
        S_ACCESS: begin
          // Last ACCESS cycle reaches TIMEOUT at most, which fits CW bits.
          cnt <= cnt + CW'(1);
          ok  <= MFC;
        end
        S_RELEASE: begin
          cnt <= '0;
`ifndef ARB_FIXED_PRIO_EN
          ptr <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
`endif
        end
        default: ;
      endcase
    end
  end

  assign onehot = NREQ'(1) << gnt_id;
  assign gnt    = ((state == S_GRANT) || (state == S_ACCESS)) ? onehot : '0;
  assign EN     = (state == S_ACCESS);
  assign RW     = (state == S_ACCESS) && dir;
  assign done   = ((state == S_RELEASE) && ok) ? onehot : '0;
  assign err    = (state == S_RELEASE) && !ok;
  assign busy   = (state != S_IDLE);

endmodule
